// File: rtl/otp_auth_fsm_pkg.sv
// Shared types and constants for the OTP authenticator session controller.
// Holds the state encoding, the LFSR tap mask, the display mode nibbles and the decimalise helper.
package otp_auth_fsm_pkg;

  localparam int unsigned OTP_W   = 16;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned NDIGITS = 4;
  localparam int unsigned TIMER_W = 32;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned ATT_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_LOCKED   = 3'd3,
    ST_EXPIRED  = 3'd4
  } state_e;

  // Taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
  localparam logic [OTP_W-1:0] LFSR_TAPS = 16'h002D;

  localparam logic [DIGIT_W-1:0] MODE_UNLOCK = 4'b0111;
  localparam logic [DIGIT_W-1:0] MODE_LOCK   = 4'b0110;
  localparam logic [DIGIT_W-1:0] MODE_EXPIRE = 4'b0101;

  function automatic logic [DIGIT_W-1:0] mode_nibble(input state_e s);
    case (s)
      ST_UNLOCKED: return MODE_UNLOCK;
      ST_LOCKED:   return MODE_LOCK;
      ST_EXPIRED:  return MODE_EXPIRE;
      default:     return 4'h0;
    endcase
  endfunction

  // Folds each hex nibble into 0..9 so the OTP is always valid BCD
  function automatic logic [OTP_W-1:0] decimalise(input logic [OTP_W-1:0] v);
    logic [OTP_W-1:0] r;
    r = v;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = v[i*4 +: 4] - 4'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/otp_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every cycle out of reset.
module otp_lfsr16
  import otp_auth_fsm_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [15:0] q
);

  logic [15:0] q_d;

  always_comb begin
    q_d = {^(q & LFSR_TAPS), q[15:1]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q <= SEED;
    else       q <= q_d;
  end

endmodule

// File: rtl/otp_auth_fsm.sv
// OTP session controller: generates the code, collects four digits, compares,
// counts wrong attempts and times expiry and lockout.
module otp_auth_fsm
  import otp_auth_fsm_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int unsigned MAX_ATT       = 3,
  parameter int unsigned EXPIRE_CYCLES = 1_500_000_000,
  parameter int unsigned LOCK_CYCLES   = 1_000_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        gen,
  input  logic        digit_valid,
  input  logic [3:0]  digit_in,
  input  logic        submit,
  output logic        unlock,
  output logic        lock,
  output logic        expire,
  output logic [1:0]  wrng_att,
  output logic [15:0] user_otp,
  output logic [15:0] lfsr_otp
);

  localparam logic [TIMER_W-1:0] EXP_LAST  = TIMER_W'(EXPIRE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [ATT_W-1:0]   ATT_LAST  = ATT_W'(MAX_ATT - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(NDIGITS);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic [OTP_W-1:0]   user_q, user_d;
  logic [OTP_W-1:0]   otp_q, otp_d;
  logic               unlock_q, lock_q, expire_q;
  logic [OTP_W-1:0]   lfsr;

  otp_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .q    (lfsr)
  );

  // Next-state and datapath decode
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
    user_d  = user_q;
    otp_d   = otp_q;
    case (state_q)
      ST_IDLE, ST_UNLOCKED, ST_EXPIRED: begin
        if (gen) begin
          otp_d   = decimalise(lfsr);
          user_d  = '0;
          cnt_d   = '0;
          att_d   = '0;
          timer_d = '0;
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        timer_d = timer_q + 32'd1;
        // Expiry outranks a same-cycle submit; a digit alongside submit is dropped
        if (timer_q == EXP_LAST) begin
          timer_d = '0;
          state_d = ST_EXPIRED;
        end else if (submit) begin
          if (cnt_q == CNT_FULL) begin
            if (user_q == otp_q) begin
              timer_d = '0;
              state_d = ST_UNLOCKED;
            end else if (att_q == ATT_LAST) begin
              timer_d = '0;
              state_d = ST_LOCKED;
            end else begin
              att_d  = att_q + 2'd1;
              user_d = '0;
              cnt_d  = '0;
            end
          end
        end else if (digit_valid && (digit_in <= 4'd9) && (cnt_q != CNT_FULL)) begin
          user_d = {user_q[11:0], digit_in};
          cnt_d  = cnt_q + 3'd1;
        end
      end
      ST_LOCKED: begin
        if (timer_q == LOCK_LAST) begin
          timer_d = '0;
          att_d   = '0;
          user_d  = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      att_q    <= '0;
      user_q   <= '0;
      otp_q    <= '0;
      unlock_q <= 1'b0;
      lock_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      att_q    <= att_d;
      user_q   <= user_d;
      otp_q    <= otp_d;
      unlock_q <= (state_d == ST_UNLOCKED);
      lock_q   <= (state_d == ST_LOCKED);
      expire_q <= (state_d == ST_EXPIRED);
    end
  end

  assign unlock   = unlock_q;
  assign lock     = lock_q;
  assign expire   = expire_q;
  assign wrng_att = att_q;
  assign user_otp = user_q;
  assign lfsr_otp = otp_q;

endmodule
